// File: rtl/system_0_button_pkg.sv
// Shared definitions for the button debouncer.
// Holds the per-channel FSM encoding and the default settle time.
package system_0_button_pkg;

  typedef enum logic {
    STABLE = 1'b0,
    CHECK  = 1'b1
  } state_t;

  // 1 ms at 50 MHz
  localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;

endpackage

// File: rtl/system_0_debounce_channel.sv
// One debounced key: 2-flop sync, STABLE/CHECK FSM, settle counter, edge strobes.
// Ports: clk, reset_n, key_in (raw pin), key_out (debounced), press_pulse, release_pulse.
module system_0_debounce_channel
  import system_0_button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_in,
  output logic key_out,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int          CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic        IDLE = (ACTIVE_LOW != 0);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          sync1;
  logic          sync2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1         <= IDLE;
      sync2         <= IDLE;
      key_out       <= IDLE;
      state         <= STABLE;
      cnt           <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      sync1         <= key_in;
      sync2         <= sync1;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      unique case (state)
        STABLE: begin
          if (sync2 != key_out) begin
            state <= CHECK;
            cnt   <= ONE;
          end else begin
            cnt   <= '0;
          end
        end
        CHECK: begin
          if (sync2 == key_out) begin
            // bounced back before settling
            state <= STABLE;
            cnt   <= '0;
          end else if (cnt == LAST) begin
            key_out       <= sync2;
            state         <= STABLE;
            cnt           <= '0;
            press_pulse   <= (sync2 != IDLE);
            release_pulse <= (sync2 == IDLE);
          end else begin
            cnt <= cnt + ONE;
          end
        end
        default: begin
          state <= STABLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/system_0_button_debounce.sv
// WIDTH independent key debouncers for a PIO input port.
// Ports: clk, reset_n, key_in[W], key_out[W], press_pulse[W], release_pulse[W].
module system_0_button_debounce
  import system_0_button_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] key_in,
  output logic [WIDTH-1:0] key_out,
  output logic [WIDTH-1:0] press_pulse,
  output logic [WIDTH-1:0] release_pulse
);

  if (WIDTH < 1) begin : g_bad_width
    $error("WIDTH must be at least 1");
  end

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (1 << 20)) begin : g_bad_cycles
    $error("DEBOUNCE_CYCLES must be in 2..2^20");
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    system_0_debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW)
    ) u_ch (
      .clk          (clk),
      .reset_n      (reset_n),
      .key_in       (key_in[i]),
      .key_out      (key_out[i]),
      .press_pulse  (press_pulse[i]),
      .release_pulse(release_pulse[i])
    );
  end

endmodule

// File: tb/tb_system_0_button_debounce.sv
// Scoreboard bench for system_0_button_debounce (WIDTH=4, 8 settle cycles).
// Stimulus queues expected strobes; a negedge monitor pops and checks them.
module tb_system_0_button_debounce;

  localparam int W  = 4;
  localparam int DC = 8;

  logic         clk;
  logic         reset_n;
  logic [W-1:0] key_in;
  logic [W-1:0] key_out;
  logic [W-1:0] press_pulse;
  logic [W-1:0] release_pulse;

  typedef struct {
    int           cyc;
    logic [W-1:0] p;
    logic [W-1:0] r;
    logic [W-1:0] k;
  } ev_t;

  ev_t          q[$];
  int           cyc;
  int           total;
  int           bad;
  logic [W-1:0] kout_exp;
  logic         mon_on;

  system_0_button_debounce #(
    .WIDTH          (W),
    .DEBOUNCE_CYCLES(DC),
    .ACTIVE_LOW     (1)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .key_in       (key_in),
    .key_out      (key_out),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, req);
    end
  endtask

  task automatic push(input int c, input logic [W-1:0] p,
                      input logic [W-1:0] r, input logic [W-1:0] k);
    ev_t e;
    e.cyc = c;
    e.p   = p;
    e.r   = r;
    e.k   = k;
    q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // monitor / scoreboard
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        if ((press_pulse | release_pulse) != '0) begin
          chk("pulse_excl", int'(press_pulse & release_pulse), 0);
          if (q.size() == 0) begin
            chk("unexpected_pulse",
                int'({press_pulse, release_pulse}), 0);
          end else begin
            e = q.pop_front();
            chk("pulse_cyc", cyc, e.cyc);
            chk("press", int'(press_pulse), int'(e.p));
            chk("release", int'(release_pulse), int'(e.r));
            kout_exp = e.k;
          end
        end else if (q.size() != 0 && q[0].cyc < cyc) begin
          e = q.pop_front();
          chk("missed_pulse_at", cyc, e.cyc);
          kout_exp = e.k;
        end
        chk("key_out", int'(key_out), int'(kout_exp));
      end
    end
  end

  initial begin
    int c;
    int r;
    total    = 0;
    bad      = 0;
    mon_on   = 1'b0;
    kout_exp = 4'hF;
    reset_n  = 1'b0;
    key_in   = 4'hF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_key_out", int'(key_out), 'hF);
    chk("rst_press", int'(press_pulse), 0);
    chk("rst_release", int'(release_pulse), 0);
    step(1);
    reset_n = 1'b1;
    mon_on  = 1'b1;

    // idle for 100 cycles
    step(100);

    // single press / release on channel 0
    c = cyc;
    key_in[0] = 1'b0;
    push(c + 1 + DC + 1, 4'h1, 4'h0, 4'hE);
    step(15);
    c = cyc;
    key_in[0] = 1'b1;
    push(c + 1 + DC + 1, 4'h0, 4'h1, 4'hF);
    step(15);

    // bouncing channel 1, excursions of 3 cycles
    for (int i = 0; i < 14; i++) begin
      key_in[1] = ~key_in[1];
      step(3);
    end
    key_in[1] = 1'b1;
    step(15);

    // channel 2: 7-cycle low rejected
    key_in[2] = 1'b0;
    step(7);
    key_in[2] = 1'b1;
    step(15);

    // channel 2: 8-cycle low accepted, then released
    c = cyc;
    key_in[2] = 1'b0;
    push(c + 1 + DC + 1, 4'h4, 4'h0, 4'hB);
    step(8);
    c = cyc;
    key_in[2] = 1'b1;
    push(c + 1 + DC + 1, 4'h0, 4'h4, 4'hF);
    step(15);

    // all channels together
    c = cyc;
    key_in = 4'h0;
    push(c + 1 + DC + 1, 4'hF, 4'h0, 4'h0);
    step(15);
    c = cyc;
    key_in = 4'hF;
    push(c + 1 + DC + 1, 4'h0, 4'hF, 4'hF);
    step(15);

    // reset in the middle of a press on channel 3 (counter at 5)
    key_in[3] = 1'b0;
    step(7);
    reset_n = 1'b0;
    @(negedge clk);
    chk("midrst_key_out", int'(key_out), 'hF);
    step(2);
    reset_n = 1'b1;
    r = cyc;
    push(r + 1 + DC + 1, 4'h8, 4'h0, 4'h7);
    step(15);
    c = cyc;
    key_in[3] = 1'b1;
    push(c + 1 + DC + 1, 4'h0, 4'h8, 4'hF);

    // drain scoreboard with a bound
    for (int i = 0; i < 200 && q.size() != 0; i++) step(1);
    chk("queue_drained", q.size(), 0);
    step(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
